// File: rtl/mem_sched_pkg.sv
// Shared constants and record types for the memory port scheduler.
package mem_sched_pkg;
   localparam int NUM_PORTS  = 4;
   localparam int MEM_LAT    = 5;
   localparam int WR_HAZ_WIN = 4;
   localparam int ID_W       = 4;   // wide enough for up to 16 requesters
   localparam int SB_ADDR_W  = 16;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            is_write;
   } inflight_t;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] addr;
   } sb_entry_t;
endpackage

// File: rtl/mem_sched_rr_picker.sv
// Rotating scan from ptr that picks up to NUM_PORTS eligible requesters,
// skipping any that collide (same address, either side a write) with an earlier pick.
module mem_sched_rr_picker
   import mem_sched_pkg::*;
#(
   parameter int NUM_REQ  = 8,
   parameter int IDX_SIZE = 4
) (
   input  logic [ID_W-1:0]                 ptr,
   input  logic [NUM_REQ-1:0]              elig,
   input  logic [NUM_REQ*IDX_SIZE-1:0]     addr,
   input  logic [NUM_REQ-1:0]              we,
   output logic [NUM_PORTS-1:0]            gnt_vld,
   output logic [NUM_PORTS-1:0][ID_W-1:0]  gnt_idx,
   output logic [ID_W-1:0]                 last_idx
);
   logic [IDX_SIZE-1:0]  g_addr [NUM_PORTS];
   logic [NUM_PORTS-1:0] g_we;
   logic [IDX_SIZE-1:0]  c_addr;
   logic                 c_we, c_elig, hit;

   always_comb begin
      int r;
      int cnt;
      gnt_vld  = '0;
      gnt_idx  = '0;
      last_idx = '0;
      g_we     = '0;
      for (int k = 0; k < NUM_PORTS; k++) g_addr[k] = '0;
      c_addr = '0;
      c_we   = 1'b0;
      c_elig = 1'b0;
      hit    = 1'b0;
      cnt    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         r = int'(ptr) + i;
         if (r >= NUM_REQ) r = r - NUM_REQ;
         c_addr = '0;
         c_we   = 1'b0;
         c_elig = 1'b0;
         for (int j = 0; j < NUM_REQ; j++)
            if (j == r) begin
               c_addr = addr[j*IDX_SIZE +: IDX_SIZE];
               c_we   = we[j];
               c_elig = elig[j];
            end
         hit = 1'b0;
         for (int k = 0; k < NUM_PORTS; k++)
            if (gnt_vld[k] && g_addr[k] == c_addr && (c_we || g_we[k])) hit = 1'b1;
         if (c_elig && !hit && cnt < NUM_PORTS) begin
            for (int k = 0; k < NUM_PORTS; k++)
               if (k == cnt) begin
                  gnt_vld[k] = 1'b1;
                  gnt_idx[k] = ID_W'(r);
                  g_addr[k]  = c_addr;
                  g_we[k]    = c_we;
               end
            last_idx = ID_W'(r);
            cnt      = cnt + 1;
         end
      end
   end
endmodule

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler sharing a 4-port, 5-cycle memory among NUM_REQ requesters.
// Define MEM_SCHED_CHECK_EN to enable simulation-only protocol/invariant checks.
module mem_port_scheduler
   import mem_sched_pkg::*;
#(
   parameter int NUM_REQ  = 8,
   parameter int WIDTH    = 32,
   parameter int SIZE     = 16,
   parameter int IDX_SIZE = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_val,
   output logic [NUM_REQ-1:0]            req_rdy,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*IDX_SIZE-1:0]   req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]            resp_val,
   output logic [NUM_REQ*WIDTH-1:0]      resp_data,
   output logic [NUM_PORTS-1:0]          mem_en,
   output logic [NUM_PORTS-1:0]          mem_we,
   output logic [NUM_PORTS*IDX_SIZE-1:0] mem_addr,
   output logic [NUM_PORTS*WIDTH-1:0]    mem_wdata,
   input  logic [NUM_PORTS*WIDTH-1:0]    mem_rdata
);
   localparam int IW = IDX_SIZE;

   if (IDX_SIZE != $clog2(SIZE) || NUM_REQ > (1 << ID_W) || NUM_REQ < 2) begin : g_bad_cfg
      $error("mem_port_scheduler: unsupported parameter set");
   end

   logic                          active, go;
   logic [ID_W-1:0]               ptr;
   inflight_t                     pipe [NUM_PORTS][MEM_LAT];
   sb_entry_t                     sb   [WR_HAZ_WIN][NUM_PORTS];
   logic [NUM_REQ-1:0]            sb_hit, elig;
   logic [NUM_PORTS-1:0]          gnt_vld;
   logic [NUM_PORTS-1:0][ID_W-1:0] gnt_idx;
   logic [ID_W-1:0]               last_idx;

   // Grants are held off during reset and the first cycle after it.
   assign go = active & ~reset;

   always_comb begin
      sb_hit = '0;
      for (int r = 0; r < NUM_REQ; r++)
         for (int w = 0; w < WR_HAZ_WIN; w++)
            for (int p = 0; p < NUM_PORTS; p++)
               if (sb[w][p].valid && sb[w][p].addr == SB_ADDR_W'(req_addr[r*IW +: IW]))
                  sb_hit[r] = 1'b1;
   end

   assign elig = req_val & ~sb_hit & {NUM_REQ{go}};

   mem_sched_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_SIZE(IDX_SIZE)) u_pick (
      .ptr      (ptr),
      .elig     (elig),
      .addr     (req_addr),
      .we       (req_we),
      .gnt_vld  (gnt_vld),
      .gnt_idx  (gnt_idx),
      .last_idx (last_idx)
   );

   always_comb begin
      req_rdy   = '0;
      mem_en    = '0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int k = 0; k < NUM_PORTS; k++)
         if (gnt_vld[k]) begin
            mem_en[k] = 1'b1;
            for (int j = 0; j < NUM_REQ; j++)
               if (gnt_idx[k] == ID_W'(j)) begin
                  req_rdy[j]                = 1'b1;
                  mem_we[k]                 = req_we[j];
                  mem_addr[k*IW +: IW]      = req_addr[j*IW +: IW];
                  mem_wdata[k*WIDTH +: WIDTH] = req_wdata[j*WIDTH +: WIDTH];
               end
         end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active <= 1'b0;
         ptr    <= '0;
         for (int p = 0; p < NUM_PORTS; p++)
            for (int s = 0; s < MEM_LAT; s++) pipe[p][s] <= '0;
         for (int w = 0; w < WR_HAZ_WIN; w++)
            for (int p = 0; p < NUM_PORTS; p++) sb[w][p] <= '0;
      end else begin
         active <= 1'b1;
         if (|gnt_vld)
            ptr <= (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + 1'b1;
         for (int p = 0; p < NUM_PORTS; p++) begin
            pipe[p][0] <= '{valid: gnt_vld[p], id: gnt_idx[p], is_write: mem_we[p]};
            for (int s = 1; s < MEM_LAT; s++) pipe[p][s] <= pipe[p][s-1];
            sb[0][p] <= '{valid: gnt_vld[p] & mem_we[p],
                          addr:  SB_ADDR_W'(mem_addr[p*IW +: IW])};
            for (int w = 1; w < WR_HAZ_WIN; w++) sb[w][p] <= sb[w-1][p];
         end
      end
   end

   // Each requester holds at most one slot per issue cycle, so ids never collide at the tail.
   always_comb begin
      resp_val  = '0;
      resp_data = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         for (int r = 0; r < NUM_REQ; r++)
            if (!reset && pipe[p][MEM_LAT-1].valid && pipe[p][MEM_LAT-1].id == ID_W'(r)) begin
               resp_val[r] = 1'b1;
               resp_data[r*WIDTH +: WIDTH] = pipe[p][MEM_LAT-1].is_write ? '0
                                           : mem_rdata[p*WIDTH +: WIDTH];
            end
   end

`ifdef MEM_SCHED_CHECK_EN
   logic [NUM_REQ-1:0]       prev_val, prev_rdy, prev_we;
   logic [NUM_REQ*IW-1:0]    prev_addr;
   logic [NUM_REQ*WIDTH-1:0] prev_wdata;

   always_ff @(posedge clk) begin
      prev_val   <= reset ? '0 : req_val;
      prev_rdy   <= req_rdy;
      prev_we    <= req_we;
      prev_addr  <= req_addr;
      prev_wdata <= req_wdata;
      if (!reset) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (req_val[r] && int'(req_addr[r*IW +: IW]) >= SIZE)
               $error("mem_port_scheduler: requester %0d address out of range", r);
            if (prev_val[r] && !prev_rdy[r] &&
                (!req_val[r] || req_we[r] != prev_we[r] ||
                 req_addr[r*IW +: IW] != prev_addr[r*IW +: IW] ||
                 req_wdata[r*WIDTH +: WIDTH] != prev_wdata[r*WIDTH +: WIDTH]))
               $error("mem_port_scheduler: requester %0d changed request before grant", r);
         end
         for (int p = 0; p < NUM_PORTS; p++)
            if (mem_en[p] && mem_we[p])
               for (int w = 0; w < WR_HAZ_WIN; w++)
                  for (int q = 0; q < NUM_PORTS; q++)
                     if (sb[w][q].valid && sb[w][q].addr == SB_ADDR_W'(mem_addr[p*IW +: IW]))
                        $error("mem_port_scheduler: port %0d write hits in-flight write", p);
      end
   end
`endif
endmodule
